gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl.sv | 151 +++++++++++++++
 tb/tb_gpio_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// GPIO controller: direction/output/mask registers, synchronized inputs and
// edge-triggered interrupts. Define GPIO_DEBOUNCE_EN to add per-pin debounce filters.
module gpio_ctrl #(
  parameter int         PIN       = 8,
  parameter logic [6:0] BASE      = 7'h78,
  parameter int         DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      addr,
  input  logic            wen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [PIN-1:0]  gpio_in,
  output logic [PIN-1:0]  gpio_out,
  output logic [PIN-1:0]  gpio_oe,
  output logic            irq
);

  localparam logic [2:0] OFF_DIR  = 3'd0;
  localparam logic [2:0] OFF_OUT  = 3'd1;
  localparam logic [2:0] OFF_MASK = 3'd2;
  localparam logic [2:0] OFF_IN   = 3'd3;
  localparam logic [2:0] OFF_IE   = 3'd4;
  localparam logic [2:0] OFF_EDGE = 3'd5;
  localparam logic [2:0] OFF_ISR  = 3'd6;
  localparam logic [2:0] OFF_TGL  = 3'd7;

  logic [PIN-1:0] dir_q, dir_d, out_q, out_d, mask_q, mask_d;
  logic [PIN-1:0] ie_q, ie_d, edge_q, edge_d, isr_q, isr_d;
  logic [PIN-1:0] sync1_q, sync2_q, p_q, f;
  logic [PIN-1:0] wd, rise, fall, isr_set, w1c;
  logic [1:0]     wu_q;
  logic [7:0]     diff;
  logic [2:0]     off;
  logic           hit, we;
  logic           unused_wdata;

  // 8-bit difference so addresses below BASE wrap into the upper bits and miss
  assign diff = {1'b0, addr} - {1'b0, BASE};
  assign hit  = (diff[7:3] == 5'd0);
  assign off  = diff[2:0];
  assign we   = wen & hit;
  assign wd   = wdata[PIN-1:0];
  assign unused_wdata = ^wdata;

`ifdef GPIO_DEBOUNCE_EN
  logic [PIN-1:0][7:0] dbc_q;
  logic [PIN-1:0]      f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dbc_q <= '0;
      f_q   <= '0;
    end else begin
      for (int i = 0; i < PIN; i++) begin
        if (sync2_q[i] != f_q[i]) begin
          if (dbc_q[i] == 8'(DB_CYCLES - 1)) begin
            f_q[i]   <= sync2_q[i];
            dbc_q[i] <= '0;
          end else begin
            dbc_q[i] <= dbc_q[i] + 8'd1;
          end
        end else begin
          dbc_q[i] <= '0;
        end
      end
    end
  end

  assign f = f_q;
`else
  assign f = sync2_q;
`endif

  assign rise = f & ~p_q;
  assign fall = ~f & p_q;

  always_comb begin
    dir_d  = dir_q;
    out_d  = out_q;
    mask_d = mask_q;
    ie_d   = ie_q;
    edge_d = edge_q;
    w1c    = '0;
    if (we) begin
      case (off)
        OFF_DIR:  dir_d  = wd;
        OFF_OUT:  out_d  = wd;
        OFF_MASK: mask_d = wd;
        OFF_IE:   ie_d   = wd;
        OFF_EDGE: edge_d = wd;
        OFF_ISR:  w1c    = wd;
        OFF_TGL:  out_d  = out_q ^ wd;
        default:  ;
      endcase
    end
    // Warm-up gates detection; a fresh edge wins over a same-cycle clear
    isr_set = '0;
    if (wu_q == 2'd0)
      isr_set = ~dir_q & ((edge_q & rise) | (~edge_q & fall));
    isr_d = (isr_q & ~w1c) | isr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      ie_q    <= '0;
      edge_q  <= '0;
      isr_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      p_q     <= '0;
      wu_q    <= 2'd3;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      ie_q    <= ie_d;
      edge_q  <= edge_d;
      isr_q   <= isr_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      p_q     <= f;
      if (wu_q != 2'd0) wu_q <= wu_q - 2'd1;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_DIR:  rdata[PIN-1:0] = dir_q;
        OFF_OUT:  rdata[PIN-1:0] = out_q;
        OFF_MASK: rdata[PIN-1:0] = mask_q;
        OFF_IN:   rdata[PIN-1:0] = sync2_q;
        OFF_IE:   rdata[PIN-1:0] = ie_q;
        OFF_EDGE: rdata[PIN-1:0] = edge_q;
        OFF_ISR:  rdata[PIN-1:0] = isr_q;
        default:  ;
      endcase
    end
  end

  assign gpio_out = out_q & mask_q & dir_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(isr_q & ie_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register vector table with a scoreboard
// queue, plus directed interrupt, collision, reset and warm-up sequences.
module tb_gpio_ctrl;

  localparam logic [6:0] B = 7'h78;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DBX = 4;
`else
  localparam int DBX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  addr = '0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out, gpio_oe;
  logic        irq;

  int n_run = 0;
  int n_fail = 0;

  gpio_ctrl #(.PIN(8), .BASE(B), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata), .rdata(rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  waddr;
    logic [31:0] wdat;
    logic [6:0]  raddr;
    logic [31:0] rexp;
    logic [7:0]  out_exp;
    logic [7:0]  oe_exp;
  } vec_t;

  typedef struct {
    logic [6:0]  raddr;
    logic [31:0] rexp;
    logic [7:0]  out_exp;
    logic [7:0]  oe_exp;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [2:0] o, input logic [31:0] exp);
    addr = B + 7'(o);
    #1;
    chk(nm, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    vecs[0] = '{B+7'd0, 32'h0000_00FF, B+7'd0, 32'h0000_00FF, 8'h00, 8'hFF};
    vecs[1] = '{B+7'd2, 32'h0000_000F, B+7'd2, 32'h0000_000F, 8'h00, 8'hFF};
    vecs[2] = '{B+7'd1, 32'hFFFF_FFA5, B+7'd1, 32'h0000_00A5, 8'h05, 8'hFF};
    vecs[3] = '{B+7'd7, 32'h0000_00FF, B+7'd7, 32'h0000_0000, 8'h0A, 8'hFF};
    vecs[4] = '{B+7'd3, 32'h0000_0055, B+7'd3, 32'h0000_0000, 8'h0A, 8'hFF};
    vecs[5] = '{7'h77,  32'h0000_0000, 7'h77,  32'h0000_0000, 8'h0A, 8'hFF};
    vecs[6] = '{7'h00,  32'h0000_0000, B+7'd2, 32'h0000_000F, 8'h0A, 8'hFF};
    vecs[7] = '{B+7'd2, 32'h0000_00FF, B+7'd1, 32'h0000_005A, 8'h5A, 8'hFF};
    vecs[8] = '{B+7'd0, 32'h0000_000F, B+7'd0, 32'h0000_000F, 8'h0A, 8'h0F};

    // Reset state
    tick();
    tick();
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk_reg("rst_in", 3'd3, 32'h0);
    chk_reg("rst_isr", 3'd6, 32'h0);
    rst = 1'b0;
    repeat (5) tick();

    // Register table through the scoreboard
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].waddr, vecs[i].wdat);
      sb.push_back('{vecs[i].raddr, vecs[i].rexp, vecs[i].out_exp, vecs[i].oe_exp});
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, e.rexp);
      chk($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(e.out_exp));
      chk($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(e.oe_exp));
    end

    // Rising edge interrupt latency, then W1C
    wr(B+7'd0, 32'h00);
    wr(B+7'd5, 32'h01);
    wr(B+7'd4, 32'h01);
    gpio_in = 8'h01;
    tick();
    tick();
    chk("early_irq", 32'(irq), 32'h0);
    chk_reg("early_isr", 3'd6, 32'h0);
    repeat (DBX) tick();
    tick();
    chk_reg("rise_isr", 3'd6, 32'h01);
    chk("rise_irq", 32'(irq), 32'h1);
    wr(B+7'd6, 32'h01);
    chk_reg("w1c_isr", 3'd6, 32'h0);
    chk("w1c_irq", 32'(irq), 32'h0);

    // Falling edge on a rising-configured pin is ignored
    gpio_in = 8'h00;
    repeat (3 + DBX) tick();
    chk_reg("fall_ign_isr", 3'd6, 32'h0);

    // Pin 2 falling-edge mode, interrupt disabled: ISR sets, irq stays low
    gpio_in = 8'h04;
    repeat (3 + DBX) tick();
    chk_reg("p2_rise_isr", 3'd6, 32'h0);
    gpio_in = 8'h00;
    repeat (3 + DBX) tick();
    chk_reg("p2_fall_isr", 3'd6, 32'h04);
    chk("p2_irq", 32'(irq), 32'h0);

    // Output-direction pin edges are ignored
    wr(B+7'd0, 32'h08);
    wr(B+7'd5, 32'h09);
    gpio_in = 8'h08;
    repeat (3 + DBX) tick();
    chk_reg("dir_ign_isr", 3'd6, 32'h04);
    gpio_in = 8'h00;
    repeat (3 + DBX) tick();
    wr(B+7'd0, 32'h00);

    // Set and W1C collide on bit 0; bit 2 clears normally
    gpio_in = 8'h01;
    tick();
    tick();
    repeat (DBX) tick();
    wr(B+7'd6, 32'h05);
    chk_reg("coll_isr", 3'd6, 32'h01);
    chk("coll_irq", 32'(irq), 32'h1);
    gpio_in = 8'h00;
    repeat (3 + DBX) tick();
    wr(B+7'd6, 32'hFF);
    chk_reg("clr_all_isr", 3'd6, 32'h0);

    // Mid-run reset with ISR=FF, OUT=FF
    wr(B+7'd5, 32'hFF);
    wr(B+7'd4, 32'hFF);
    gpio_in = 8'hFF;
    repeat (3 + DBX) tick();
    chk_reg("all_isr", 3'd6, 32'hFF);
    chk("all_irq", 32'(irq), 32'h1);
    wr(B+7'd1, 32'hFF);
    wr(B+7'd2, 32'hFF);
    wr(B+7'd0, 32'hFF);
    chk("pre_rst_out", 32'(gpio_out), 32'hFF);
    rst = 1'b1;
    tick();
    chk_reg("mid_rst_isr", 3'd6, 32'h0);
    chk_reg("mid_rst_out_reg", 3'd1, 32'h0);
    chk("mid_rst_out", 32'(gpio_out), 32'h0);
    chk("mid_rst_oe", 32'(gpio_oe), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    tick();

    // Static high pins across reset release raise nothing
    rst = 1'b0;
    wr(B+7'd5, 32'hFF);
    wr(B+7'd4, 32'hFF);
    for (int i = 0; i < 10; i++) begin
`ifndef GPIO_DEBOUNCE_EN
      chk_reg($sformatf("warm_isr%0d", i), 3'd6, 32'h0);
      chk($sformatf("warm_irq%0d", i), 32'(irq), 32'h0);
`endif
      tick();
    end
    chk_reg("warm_in", 3'd3, 32'hFF);

`ifdef GPIO_DEBOUNCE_EN
    // Glitch filtering on pin 1 (falling-edge mode)
    wr(B+7'd5, 32'h00);
    wr(B+7'd6, 32'hFF);
    gpio_in = 8'hFD;
    repeat (3) tick();
    gpio_in = 8'hFF;
    repeat (10) tick();
    chk_reg("db_glitch_isr", 3'd6, 32'h0);
    gpio_in = 8'hFD;
    repeat (5) tick();
    gpio_in = 8'hFF;
    repeat (8) tick();
    chk_reg("db_pulse_isr", 3'd6, 32'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
